// File: rtl/isq_iss_ctl_pkg.sv
// isq_pkg: shared widths and FSM encoding for the issue-queue read/control end.
package isq_pkg;
  localparam int INST_WIDTH = 56;
  localparam int ISQ_DEPTH  = 16;
  localparam int IDX_WIDTH  = $clog2(ISQ_DEPTH);
  localparam int CNT_WIDTH  = $clog2(ISQ_DEPTH + 1);
  localparam int LINE_W     = INST_WIDTH + 1;
  typedef enum logic {S_RUN, S_FLUSH} state_e;
endpackage

// File: rtl/isq_iss_ctl_if.sv
// isq_iss_ctl_if: queue-line, dispatch and issue-stage signals of the issue control block.
interface isq_iss_ctl_if
  import isq_pkg::*;
  ();
  logic [ISQ_DEPTH*LINE_W-1:0] lin_bus;
  logic [ISQ_DEPTH-1:0]        rdy_vec;
  logic                        dsp_vld;
  logic                        dsp_rdy;
  logic [ISQ_DEPTH-1:0]        dsp_wr_vec;
  logic [ISQ_DEPTH-1:0]        shift_en_vec;
  logic [ISQ_DEPTH-1:0]        clr_wat_vec;
  logic [ISQ_DEPTH-1:0]        fls_inst_vec;
  logic                        flush;
  logic                        iss_vld;
  logic                        iss_rdy;
  logic [INST_WIDTH-1:0]       iss_inst;
  logic [IDX_WIDTH-1:0]        iss_idx;
  logic [CNT_WIDTH-1:0]        isq_cnt;
  modport master (
    input  lin_bus, rdy_vec, dsp_vld, flush, iss_rdy,
    output dsp_rdy, dsp_wr_vec, shift_en_vec, clr_wat_vec, fls_inst_vec,
           iss_vld, iss_inst, iss_idx, isq_cnt
  );
  modport slave (
    output lin_bus, rdy_vec, dsp_vld, flush, iss_rdy,
    input  dsp_rdy, dsp_wr_vec, shift_en_vec, clr_wat_vec, fls_inst_vec,
           iss_vld, iss_inst, iss_idx, isq_cnt
  );
endinterface

// File: rtl/isq_iss_ctl_pri_enc.sv
// isq_pri_enc: lowest-index priority encoder returning {found, idx}.
module isq_pri_enc #(
  parameter int N  = 16,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  output logic          found,
  output logic [IW-1:0] idx
);
  always_comb begin
    found = |req;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
  end
endmodule

// File: rtl/isq_iss_ctl.sv
// isq_iss_ctl: oldest-ready select, issue stage register and collapse/dispatch/flush controls.
// Optional ISQ_STALL_CNT_EN adds a saturating issue-stall cycle counter output.
module isq_iss_ctl
  import isq_pkg::*;
(
  input logic clk,
  input logic rst_n,
  isq_iss_ctl_if.master bus
`ifdef ISQ_STALL_CNT_EN
  , output logic [15:0] iss_stall_cnt
`endif
);
  state_e state, state_nxt;
  logic [ISQ_DEPTH-1:0] cand;
  logic [IDX_WIDTH-1:0] sel;
  logic [CNT_WIDTH-1:0] wr;
  logic found, run, fire, dec, dsp_go, flushing, clr;
  for (genvar i = 0; i < ISQ_DEPTH; i++) begin : g_cand
    assign cand[i] = bus.lin_bus[(i+1)*LINE_W-1] & bus.rdy_vec[i];
  end
  isq_pri_enc #(.N(ISQ_DEPTH), .IW(IDX_WIDTH)) u_enc (.req(cand), .found(found), .idx(sel));
  // Dispatch lands on the post-collapse tail, so that line must not also shift.
  always_comb begin
    run = rst_n && state == S_RUN && !bus.flush;
    fire = run && found && (!bus.iss_vld || bus.iss_rdy);
    dec = fire && bus.isq_cnt != '0;
    wr = bus.isq_cnt - CNT_WIDTH'(dec);
    bus.dsp_rdy = run && bus.isq_cnt < CNT_WIDTH'(ISQ_DEPTH);
    dsp_go = bus.dsp_vld && bus.dsp_rdy;
    bus.dsp_wr_vec = dsp_go ? ISQ_DEPTH'(1) << wr : '0;
    flushing = rst_n && state == S_FLUSH;
    clr = bus.flush || state == S_FLUSH;
    bus.clr_wat_vec = flushing ? '1 : fire ? ISQ_DEPTH'(1) << sel : '0;
    bus.fls_inst_vec = flushing ? '1 : fire ? {1'b1, {(ISQ_DEPTH-1){1'b0}}} : '0;
    bus.shift_en_vec = fire ? ({1'b0, {(ISQ_DEPTH-1){1'b1}}} & ({ISQ_DEPTH{1'b1}} << sel) & ~bus.dsp_wr_vec) : '0;
    state_nxt = bus.flush ? S_FLUSH : S_RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_RUN;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.iss_vld <= 1'b0;
      bus.iss_inst <= '0;
      bus.iss_idx <= '0;
      bus.isq_cnt <= '0;
    end else if (clr) begin
      bus.iss_vld <= 1'b0;
      bus.isq_cnt <= '0;
    end else begin
      bus.isq_cnt <= bus.isq_cnt + CNT_WIDTH'(dsp_go) - CNT_WIDTH'(dec);
      if (fire) begin
        bus.iss_vld <= 1'b1;
        bus.iss_inst <= bus.lin_bus[int'(sel)*LINE_W +: INST_WIDTH];
        bus.iss_idx <= sel;
      end else if (bus.iss_rdy) bus.iss_vld <= 1'b0;
    end
`ifdef ISQ_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) iss_stall_cnt <= '0;
    else if (clr) iss_stall_cnt <= '0;
    else if (bus.iss_vld && !bus.iss_rdy && iss_stall_cnt != 16'hFFFF) iss_stall_cnt <= iss_stall_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_isq_iss_ctl.sv
// tb_isq_iss_ctl: directed self-checking bench for isq_iss_ctl.
module tb_isq_iss_ctl;
  import isq_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int pass = 0;
  int total = 0;
  isq_iss_ctl_if bus();
`ifdef ISQ_STALL_CNT_EN
  logic [15:0] iss_stall_cnt;
  isq_iss_ctl dut (.clk(clk), .rst_n(rst_n), .bus(bus), .iss_stall_cnt(iss_stall_cnt));
`else
  isq_iss_ctl dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;

  function automatic logic [INST_WIDTH-1:0] inst_of(input int i);
    return {8'hA5, 16'(i), 32'hC0DE0000 + 32'(i)};
  endfunction

  function automatic logic [ISQ_DEPTH*LINE_W-1:0] mk_bus(input logic [15:0] wat);
    logic [ISQ_DEPTH*LINE_W-1:0] b;
    for (int i = 0; i < ISQ_DEPTH; i++) b[i*LINE_W +: LINE_W] = {wat[i], inst_of(i)};
    return b;
  endfunction

  task automatic drive(input logic [15:0] wat, input logic [15:0] rdy, input logic ir, input logic dv, input logic fl);
    bus.lin_bus = mk_bus(wat);
    bus.rdy_vec = rdy;
    bus.iss_rdy = ir;
    bus.dsp_vld = dv;
    bus.flush = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(16'h0088, 16'h0088, 1'b1, 1'b1, 1'b0);
    step();
    step();
    total++; if (bus.iss_vld !== 1'b0) $display("FAIL rst_vld got %b exp 0", bus.iss_vld); else pass++;
    total++; if (bus.isq_cnt !== 5'd0) $display("FAIL rst_cnt got %0d exp 0", bus.isq_cnt); else pass++;
    total++; if (bus.iss_inst !== '0) $display("FAIL rst_inst got %h exp 0", bus.iss_inst); else pass++;
    total++; if (bus.iss_idx !== 4'd0) $display("FAIL rst_idx got %0d exp 0", bus.iss_idx); else pass++;
    total++; if (bus.clr_wat_vec !== 16'h0) $display("FAIL rst_clr got %h exp 0", bus.clr_wat_vec); else pass++;
    total++; if (bus.shift_en_vec !== 16'h0) $display("FAIL rst_shift got %h exp 0", bus.shift_en_vec); else pass++;
    total++; if (bus.fls_inst_vec !== 16'h0) $display("FAIL rst_fls got %h exp 0", bus.fls_inst_vec); else pass++;
    total++; if (bus.dsp_wr_vec !== 16'h0) $display("FAIL rst_wr got %h exp 0", bus.dsp_wr_vec); else pass++;
    drive(16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_fire();
    drive(16'h0088, 16'h0088, 1'b1, 1'b0, 1'b0);
    #1;
    total++; if (bus.clr_wat_vec !== 16'h0008) $display("FAIL fire_clr got %h exp 0008", bus.clr_wat_vec); else pass++;
    total++; if (bus.shift_en_vec !== 16'h7FF8) $display("FAIL fire_shift got %h exp 7ff8", bus.shift_en_vec); else pass++;
    total++; if (bus.fls_inst_vec !== 16'h8000) $display("FAIL fire_fls got %h exp 8000", bus.fls_inst_vec); else pass++;
    total++; if (bus.iss_vld !== 1'b0) $display("FAIL fire_pre_vld got %b exp 0", bus.iss_vld); else pass++;
    step();
    total++; if (bus.iss_vld !== 1'b1) $display("FAIL fire_vld got %b exp 1", bus.iss_vld); else pass++;
    total++; if (bus.iss_idx !== 4'd3) $display("FAIL fire_idx got %0d exp 3", bus.iss_idx); else pass++;
    total++; if (bus.iss_inst !== inst_of(3)) $display("FAIL fire_inst got %h exp %h", bus.iss_inst, inst_of(3)); else pass++;
    total++; if (bus.isq_cnt !== 5'd0) $display("FAIL fire_cnt got %0d exp 0", bus.isq_cnt); else pass++;
    drive(16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    step();
    total++; if (bus.iss_vld !== 1'b0) $display("FAIL drain_vld got %b exp 0", bus.iss_vld); else pass++;
  endtask

  task automatic test_stall();
    drive(16'h0220, 16'h0220, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (bus.iss_idx !== 4'd5) $display("FAIL stall_first_idx got %0d exp 5", bus.iss_idx); else pass++;
    drive(16'h0100, 16'h0100, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      #1;
      total++; if (bus.clr_wat_vec !== 16'h0) $display("FAIL stall_clr[%0d] got %h exp 0", c, bus.clr_wat_vec); else pass++;
      total++; if (bus.iss_idx !== 4'd5 || bus.iss_vld !== 1'b1) $display("FAIL stall_idx[%0d] got %0d/%b exp 5/1", c, bus.iss_idx, bus.iss_vld); else pass++;
      total++; if (bus.iss_inst !== inst_of(5)) $display("FAIL stall_inst[%0d] got %h exp %h", c, bus.iss_inst, inst_of(5)); else pass++;
      step();
    end
    bus.iss_rdy = 1'b1;
    #1;
    total++; if (bus.clr_wat_vec !== 16'h0100) $display("FAIL unstall_clr got %h exp 0100", bus.clr_wat_vec); else pass++;
    step();
    total++; if (bus.iss_idx !== 4'd8 || bus.iss_vld !== 1'b1) $display("FAIL unstall_idx got %0d/%b exp 8/1", bus.iss_idx, bus.iss_vld); else pass++;
    drive(16'h0, 16'h0, 1'b1, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_full();
    drive(16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < ISQ_DEPTH; i++) begin
      #1;
      total++; if (bus.dsp_wr_vec !== 16'(1) << i) $display("FAIL fill_wr[%0d] got %h exp %h", i, bus.dsp_wr_vec, 16'(1) << i); else pass++;
      step();
    end
    #1;
    total++; if (bus.isq_cnt !== 5'd16) $display("FAIL full_cnt got %0d exp 16", bus.isq_cnt); else pass++;
    total++; if (bus.dsp_rdy !== 1'b0) $display("FAIL full_rdy got %b exp 0", bus.dsp_rdy); else pass++;
    total++; if (bus.dsp_wr_vec !== 16'h0) $display("FAIL full_wr got %h exp 0", bus.dsp_wr_vec); else pass++;
    step();
    total++; if (bus.isq_cnt !== 5'd16) $display("FAIL full_hold got %0d exp 16", bus.isq_cnt); else pass++;
    drive(16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0);
    repeat (11) step();
    total++; if (bus.isq_cnt !== 5'd5) $display("FAIL drain_cnt got %0d exp 5", bus.isq_cnt); else pass++;
    drive(16'h0004, 16'h0004, 1'b1, 1'b1, 1'b0);
    #1;
    total++; if (bus.dsp_wr_vec !== 16'h0010) $display("FAIL both_wr got %h exp 0010", bus.dsp_wr_vec); else pass++;
    total++; if (bus.shift_en_vec !== 16'h7FEC) $display("FAIL both_shift got %h exp 7fec", bus.shift_en_vec); else pass++;
    total++; if (bus.clr_wat_vec !== 16'h0004) $display("FAIL both_clr got %h exp 0004", bus.clr_wat_vec); else pass++;
    step();
    total++; if (bus.isq_cnt !== 5'd5) $display("FAIL both_cnt got %0d exp 5", bus.isq_cnt); else pass++;
    total++; if (bus.iss_idx !== 4'd2) $display("FAIL both_idx got %0d exp 2", bus.iss_idx); else pass++;
  endtask

  task automatic test_flush();
    drive(16'h0, 16'h0, 1'b1, 1'b1, 1'b0);
    repeat (5) step();
    drive(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    step();
    total++; if (bus.isq_cnt !== 5'd9 || bus.iss_vld !== 1'b1) $display("FAIL preflush got %0d/%b exp 9/1", bus.isq_cnt, bus.iss_vld); else pass++;
    drive(16'h0002, 16'h0002, 1'b0, 1'b1, 1'b1);
    #1;
    total++; if (bus.dsp_rdy !== 1'b0 || bus.dsp_wr_vec !== 16'h0) $display("FAIL flush_dsp got %b/%h exp 0/0", bus.dsp_rdy, bus.dsp_wr_vec); else pass++;
    step();
    bus.flush = 1'b0;
    #1;
    total++; if (bus.iss_vld !== 1'b0) $display("FAIL flush_vld got %b exp 0", bus.iss_vld); else pass++;
    total++; if (bus.isq_cnt !== 5'd0) $display("FAIL flush_cnt got %0d exp 0", bus.isq_cnt); else pass++;
    total++; if (bus.fls_inst_vec !== 16'hFFFF) $display("FAIL flush_fls got %h exp ffff", bus.fls_inst_vec); else pass++;
    total++; if (bus.clr_wat_vec !== 16'hFFFF) $display("FAIL flush_clr got %h exp ffff", bus.clr_wat_vec); else pass++;
    total++; if (bus.dsp_rdy !== 1'b0 || bus.shift_en_vec !== 16'h0) $display("FAIL flush_quiet got %b/%h exp 0/0", bus.dsp_rdy, bus.shift_en_vec); else pass++;
    step();
    total++; if (bus.clr_wat_vec !== 16'h0002 || bus.dsp_rdy !== 1'b1) $display("FAIL postflush got %h/%b exp 0002/1", bus.clr_wat_vec, bus.dsp_rdy); else pass++;
    step();
  endtask

  task automatic test_async_reset();
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    total++; if (bus.iss_vld !== 1'b1 || bus.isq_cnt !== 5'd1) $display("FAIL prerst got %b/%0d exp 1/1", bus.iss_vld, bus.isq_cnt); else pass++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.iss_vld !== 1'b0) $display("FAIL arst_vld got %b exp 0", bus.iss_vld); else pass++;
    total++; if (bus.isq_cnt !== 5'd0) $display("FAIL arst_cnt got %0d exp 0", bus.isq_cnt); else pass++;
    total++; if (bus.iss_inst !== '0) $display("FAIL arst_inst got %h exp 0", bus.iss_inst); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

`ifdef ISQ_STALL_CNT_EN
  task automatic test_stall_cnt();
    drive(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0);
    step();
    drive(16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (70000) @(posedge clk);
    #1;
    total++; if (iss_stall_cnt !== 16'hFFFF) $display("FAIL stall_sat got %h exp ffff", iss_stall_cnt); else pass++;
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    total++; if (iss_stall_cnt !== 16'h0) $display("FAIL stall_flush got %h exp 0", iss_stall_cnt); else pass++;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_fire();
    test_stall();
    test_full();
    test_flush();
    test_async_reset();
`ifdef ISQ_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
